// File: rtl/hack_control_sequencer_pkg.sv
// hack_control_sequencer_pkg: shared state encodings, instruction field positions and strobe bundle
package hack_control_sequencer_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    MEMW  = 3'd3,
    HALT  = 3'd4,
    ERROR = 3'd5
  } state_t;
  localparam int A_BIT = 15;
  localparam int SEL_Y_BIT = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_A = 5;
  localparam int DEST_D = 4;
  localparam int DEST_M = 3;
  localparam int JUMP_LT = 2;
  localparam int JUMP_EQ = 1;
  localparam int JUMP_GT = 0;
  localparam logic [2:0] JMP_ALWAYS = 3'b111;
  typedef struct packed {
    logic load_a;
    logic load_d;
    logic write_m;
    logic pc_load;
    logic pc_inc;
  } strobes_t;
endpackage

// File: rtl/hack_control_sequencer_if.sv
// hack_control_sequencer_if: instruction fetch handshake and data-memory write handshake
//   instr/instr_valid/instr_req : ROM fetch handshake
//   write_m/mem_ack             : RAM write request and acceptance
interface hack_control_sequencer_if;
  logic [15:0] instr;
  logic instr_valid;
  logic instr_req;
  logic write_m;
  logic mem_ack;
  modport master (input instr, instr_valid, mem_ack, output instr_req, write_m);
  modport slave (output instr, instr_valid, mem_ack, input instr_req, write_m);
endinterface

// File: rtl/hack_control_sequencer_decode.sv
// hack_control_sequencer_decode: combinational Hack instruction decode into datapath controls
//   instr    : latched instruction
//   zr, ng   : ALU flags for that instruction
//   strb     : ungated strobes {load_a, load_d, write_m, pc_load, pc_inc}
//   alu_ctrl, sel_y, sel_a : datapath selects straight from the instruction
//   self_jmp : C-instruction with unconditional jump (halt candidate)
module hack_control_sequencer_decode
  import hack_control_sequencer_pkg::*;
(
  input  logic [15:0] instr,
  input  logic        zr,
  input  logic        ng,
  output strobes_t    strb,
  output logic [5:0]  alu_ctrl,
  output logic        sel_y,
  output logic        sel_a,
  output logic        self_jmp
);
  logic c_ins, take;
  logic unused_bits;
  assign unused_bits = ^instr[14:13];
  always_comb begin
    c_ins = instr[A_BIT];
    take = (instr[JUMP_LT] & ng) | (instr[JUMP_EQ] & zr) | (instr[JUMP_GT] & ~ng & ~zr);
    strb.load_a = c_ins ? instr[DEST_A] : 1'b1;
    strb.load_d = c_ins & instr[DEST_D];
    strb.write_m = c_ins & instr[DEST_M];
    strb.pc_load = c_ins & take;
    strb.pc_inc = ~(c_ins & take);
    alu_ctrl = instr[COMP_HI:COMP_LO];
    sel_y = instr[SEL_Y_BIT];
    sel_a = instr[A_BIT];
    self_jmp = c_ins & (instr[2:0] == JMP_ALWAYS);
  end
endmodule

// File: rtl/hack_control_sequencer.sv
// hack_control_sequencer: multi-cycle fetch/execute/memory-wait sequencer for the Hack CPU
//   clk, rst_n      : clock, async active-low reset (released synchronously)
//   run, step       : run level and single-step pulse (step used when STEP_EN=1)
//   pc, a_reg       : compared for self-loop halt detection
//   zr, ng          : ALU flags for the latched instruction
//   bus             : fetch handshake and memory write handshake
//   alu_ctrl, sel_y, sel_a, load_a, load_d, pc_load, pc_inc : datapath controls
//   state, halted, mem_err, instr_count : status
module hack_control_sequencer
  import hack_control_sequencer_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int CNT_W = 16,
  parameter int MEM_WAIT_MAX = 4,
  parameter int STEP_EN = 0,
  parameter int HALT_DETECT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic                    step,
  input  logic [ADDR_W-1:0]       pc,
  input  logic [ADDR_W-1:0]       a_reg,
  input  logic                    zr,
  input  logic                    ng,
  hack_control_sequencer_if.master bus,
  output logic [5:0]              alu_ctrl,
  output logic                    sel_y,
  output logic                    sel_a,
  output logic                    load_a,
  output logic                    load_d,
  output logic                    pc_load,
  output logic                    pc_inc,
  output logic [2:0]              state,
  output logic                    halted,
  output logic                    mem_err,
  output logic [CNT_W-1:0]        instr_count
);
  localparam int WW = $clog2(MEM_WAIT_MAX + 2);
  state_t st, cont;
  logic [15:0] ir;
  logic [WW-1:0] wcnt;
  logic [1:0] rsync;
  logic halt_pend, self_jmp, halt_now, go, ex, mw;
  logic [CNT_W-1:0] cnt_next;
  strobes_t dec;

  hack_control_sequencer_decode u_dec (
    .instr(ir), .zr, .ng, .strb(dec), .alu_ctrl, .sel_y, .sel_a, .self_jmp
  );

  always_comb begin
    ex = st == EXEC;
    mw = st == MEMW;
    halt_now = (HALT_DETECT != 0) && self_jmp && (a_reg == pc);
    go = run && (STEP_EN == 0 || step);
    cont = (STEP_EN == 0 && run) ? FETCH : IDLE;
    cnt_next = (instr_count == '1) ? instr_count : instr_count + 1'b1;
    load_a = ex & dec.load_a;
    load_d = ex & dec.load_d;
    pc_load = ex & dec.pc_load;
    pc_inc = ex & dec.pc_inc;
    bus.write_m = (ex & dec.write_m) | mw;
    bus.instr_req = st == FETCH;
    halted = st == HALT;
    mem_err = st == ERROR;
    state = st;
  end

  // Reset asserts immediately but the FSM only starts two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rsync <= '0;
    else rsync <= {rsync[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      ir <= '0;
      wcnt <= '0;
      halt_pend <= 1'b0;
      instr_count <= '0;
    end else if (rsync[1]) begin
      case (st)
        IDLE: if (go) st <= FETCH;
        FETCH: if (bus.instr_valid) begin
          ir <= bus.instr;
          st <= EXEC;
        end
        EXEC: begin
          // pc/a_reg may change after this cycle, so the halt decision is captured here.
          halt_pend <= halt_now;
          wcnt <= WW'(2);
          if (dec.write_m && !bus.mem_ack) st <= (MEM_WAIT_MAX <= 1) ? ERROR : MEMW;
          else begin
            instr_count <= cnt_next;
            st <= halt_now ? HALT : cont;
          end
        end
        MEMW: if (bus.mem_ack) begin
          instr_count <= cnt_next;
          st <= halt_pend ? HALT : cont;
        end else if (wcnt >= WW'(MEM_WAIT_MAX)) st <= ERROR;
        else wcnt <= wcnt + 1'b1;
        HALT: if (!run) st <= IDLE;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_hack_control_sequencer.sv
// tb_hack_control_sequencer: vector table plus scoreboard bench for the Hack control sequencer
module tb_hack_control_sequencer;
  import hack_control_sequencer_pkg::*;
  typedef struct {
    logic [15:0] instr;
    logic zr, ng;
    logic [14:0] a, p;
    int dly;
    logic [4:0] strb;
    logic halt;
  } vec_t;
  typedef struct {
    logic [15:0] instr;
    logic [4:0] strb;
  } exp_t;

  logic clk = 0, rst_n = 1, run = 0, step = 0, zr = 0, ng = 0;
  logic run1 = 0, step1 = 0, run2 = 0;
  logic [14:0] a_reg = 0, pc = 0;
  logic [5:0] alu0, alu1, alu2;
  logic sy0, sa0, la0, ld0, pl0, pi0, h0, me0;
  logic sy1, sa1, la1, ld1, pl1, pi1, h1, me1;
  logic sy2, sa2, la2, ld2, pl2, pi2, h2, me2;
  logic [2:0] st0, st1, st2;
  logic [15:0] cnt0, cnt1;
  logic [1:0] cnt2;
  int checks = 0, errors = 0, wm = 0, exp_cnt = 0;
  exp_t sb[$];
  vec_t vt[13];

  hack_control_sequencer_if b0(), b1(), b2();

  always #5 clk = ~clk;

  hack_control_sequencer u0 (
    .clk, .rst_n, .run, .step, .pc, .a_reg, .zr, .ng, .bus(b0),
    .alu_ctrl(alu0), .sel_y(sy0), .sel_a(sa0), .load_a(la0), .load_d(ld0),
    .pc_load(pl0), .pc_inc(pi0), .state(st0), .halted(h0), .mem_err(me0), .instr_count(cnt0)
  );
  hack_control_sequencer #(.STEP_EN(1)) u1 (
    .clk, .rst_n, .run(run1), .step(step1), .pc, .a_reg, .zr, .ng, .bus(b1),
    .alu_ctrl(alu1), .sel_y(sy1), .sel_a(sa1), .load_a(la1), .load_d(ld1),
    .pc_load(pl1), .pc_inc(pi1), .state(st1), .halted(h1), .mem_err(me1), .instr_count(cnt1)
  );
  hack_control_sequencer #(.CNT_W(2)) u2 (
    .clk, .rst_n, .run(run2), .step, .pc, .a_reg, .zr, .ng, .bus(b2),
    .alu_ctrl(alu2), .sel_y(sy2), .sel_a(sa2), .load_a(la2), .load_d(ld2),
    .pc_load(pl2), .pc_inc(pi2), .state(st2), .halted(h2), .mem_err(me2), .instr_count(cnt2)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, 32'({st0, b0.instr_req, b0.write_m, la0, ld0, pl0, pi0, h0, me0, sa0, sy0, alu0}), 0);
    chk({nm, "_count"}, 32'(cnt0), 0);
  endtask

  // Called at the falling edge: count write cycles and score any EXEC cycle.
  task automatic observe();
    exp_t e;
    if (b0.write_m) wm++;
    if (st0 == EXEC) begin
      if (sb.size() == 0) chk("exec_without_fetch", 32'(sb.size()), 1);
      else begin
        e = sb.pop_front();
        chk("strobes", 32'({la0, ld0, b0.write_m, pl0, pi0}), 32'(e.strb));
        chk("alu_sel", 32'({sa0, sy0, alu0}), 32'({e.instr[15], e.instr[12], e.instr[11:6]}));
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!b0.instr_req && n < 20) begin
      cyc();
      n++;
    end
    if (!b0.instr_req) chk("instr_req_timeout", 32'(b0.instr_req), 1);
  endtask

  task automatic fetch(input logic [15:0] ins, input logic [4:0] strb);
    wait_req();
    b0.instr = ins;
    b0.instr_valid = 1;
    sb.push_back('{ins, strb});
    wm = 0;
    cyc();
    b0.instr_valid = 0;
  endtask

  task automatic do_vec(input vec_t v);
    zr = v.zr;
    ng = v.ng;
    a_reg = v.a;
    pc = v.p;
    fetch(v.instr, v.strb);
    for (int j = 0; j < (v.strb[2] ? v.dly + 1 : 1); j++) begin
      b0.mem_ack = v.strb[2] && j == v.dly;
      cyc();
    end
    b0.mem_ack = 0;
    exp_cnt++;
    chk("count", 32'(cnt0), 32'(exp_cnt));
    chk("write_cycles", 32'(wm), 32'(v.strb[2] ? v.dly + 1 : 0));
    chk("next_state", 32'(st0), 32'(v.halt ? HALT : FETCH));
    if (v.halt) begin
      chk("halted", 32'(h0), 1);
      run = 0;
      cyc();
      chk("halt_exit", 32'(st0), 32'(IDLE));
      run = 1;
    end
  endtask

  initial begin
    b0.instr = 0; b0.instr_valid = 0; b0.mem_ack = 0;
    b1.instr = 16'h0005; b1.instr_valid = 1; b1.mem_ack = 0;
    b2.instr = 16'h0005; b2.instr_valid = 1; b2.mem_ack = 0;
    vt[0]  = '{16'h0005, 0, 0, 15'd1, 15'd2, 0, 5'b10001, 0};
    vt[1]  = '{16'hE308, 0, 0, 15'd1, 15'd2, 2, 5'b00101, 0};
    vt[2]  = '{16'hE302, 1, 0, 15'd1, 15'd2, 0, 5'b00010, 0};
    vt[3]  = '{16'hE302, 0, 0, 15'd1, 15'd2, 0, 5'b00001, 0};
    vt[4]  = '{16'hE301, 0, 0, 15'd1, 15'd2, 0, 5'b00010, 0};
    vt[5]  = '{16'hE304, 0, 1, 15'd1, 15'd2, 0, 5'b00010, 0};
    vt[6]  = '{16'hE304, 0, 0, 15'd1, 15'd2, 0, 5'b00001, 0};
    vt[7]  = '{16'hEC10, 0, 0, 15'd1, 15'd2, 0, 5'b01001, 0};
    vt[8]  = '{16'hFC38, 0, 0, 15'd1, 15'd2, 0, 5'b11101, 0};
    vt[9]  = '{16'hEA87, 0, 0, 15'd3, 15'd7, 0, 5'b00010, 0};
    vt[10] = '{16'hEA87, 0, 0, 15'd7, 15'd7, 0, 5'b00010, 1};
    vt[11] = '{16'hE30F, 0, 0, 15'd4, 15'd4, 1, 5'b00110, 1};
    vt[12] = '{16'hE303, 0, 1, 15'd1, 15'd2, 0, 5'b00001, 0};
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1;
    repeat (3) cyc();
    chk("idle_after_reset", 32'(st0), 32'(IDLE));
    run = 1;
    for (int i = 0; i < 13; i++) do_vec(vt[i]);
    zr = 0; ng = 0; a_reg = 1; pc = 2;
    fetch(16'h0005, 5'b10001);
    run = 0;
    cyc();
    exp_cnt++;
    chk("run_drop_state", 32'(st0), 32'(IDLE));
    chk("run_drop_count", 32'(cnt0), 32'(exp_cnt));
    repeat (2) cyc();
    chk("idle_no_req", 32'(b0.instr_req), 0);
    run = 1;
    fetch(16'hE308, 5'b00101);
    b0.mem_ack = 0;
    repeat (4) cyc();
    chk("err_write_cycles", 32'(wm), 4);
    chk("err_state", 32'(st0), 32'(ERROR));
    chk("mem_err", 32'(me0), 1);
    chk("err_count", 32'(cnt0), 32'(exp_cnt));
    b0.mem_ack = 1;
    cyc();
    b0.mem_ack = 0;
    run = 0;
    repeat (2) cyc();
    chk("err_sticky", 32'({me0, st0, b0.write_m}), 32'({1'b1, 3'd5, 1'b0}));
    rst_n = 0;
    #1;
    chk_zero("reset_from_error");
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (3) cyc();
    run = 1;
    fetch(16'hE308, 5'b00101);
    b0.mem_ack = 0;
    cyc();
    chk("in_memw", 32'(st0), 32'(MEMW));
    #2 rst_n = 0;
    #1;
    chk_zero("reset_in_memw");
    @(posedge clk);
    #1;
    rst_n = 1;
    run = 0;
    repeat (3) cyc();
    chk("scoreboard_empty", 32'(sb.size()), 0);
    run1 = 1;
    for (int p = 0; p < 3; p++) begin
      repeat (10) cyc();
      chk("step_idle", 32'(st1), 32'(IDLE));
      chk("step_count", 32'(cnt1), 32'(p));
      step1 = 1;
      cyc();
      step1 = 0;
    end
    repeat (10) cyc();
    chk("step_total", 32'(cnt1), 3);
    chk("step_final_idle", 32'(st1), 32'(IDLE));
    run2 = 1;
    repeat (5) cyc();
    chk("rate_count", 32'(cnt2), 2);
    chk("rate_state", 32'(st2), 32'(FETCH));
    repeat (20) cyc();
    chk("sat_count", 32'(cnt2), 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
